// File: rtl/bc_fetch_unit_if.sv
// rtl/bc_fetch_unit_if.sv - write port and fetch output bundle of the fetch unit
interface bc_fetch_unit_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   i_stall;
  logic                   i_wen;
  logic                   i_wdata_valid;
  logic [ADDR_WIDTH-1:0]  i_waddr;
  logic [DATA_WIDTH-1:0]  i_wdata;
  logic [ADDR_WIDTH-1:0]  o_pc;
  logic                   o_instr_valid;
  logic [INSTR_WIDTH-1:0] o_instr;

  modport master (
    output i_stall, i_wen, i_wdata_valid, i_waddr, i_wdata,
    input  o_pc, o_instr_valid, o_instr
  );

  modport slave (
    input  i_stall, i_wen, i_wdata_valid, i_waddr, i_wdata,
    output o_pc, o_instr_valid, o_instr
  );
endinterface

// File: rtl/bc_fetch_unit.sv
// rtl/bc_fetch_unit.sv - instruction fetch stage with its word-addressed instruction memory
module bc_fetch_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int WORD_NUM    = 1024
) (
  input logic            i_clk,
  input logic            i_rst,
  bc_fetch_unit_if.slave bus
);
  localparam int IDX_W = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH     = ADDR_WIDTH'(WORD_NUM);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_NUM - 1);

  logic [DATA_WIDTH-1:0] mem_q [WORD_NUM] = '{default: '0};

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   s1_valid_q;
  logic [ADDR_WIDTH-1:0]  s1_addr_q;
  logic [DATA_WIDTH-1:0]  s1_data_q;
  logic                   out_valid_q;
  logic [ADDR_WIDTH-1:0]  out_pc_q;
  logic [INSTR_WIDTH-1:0] out_instr_q;
  logic                   wr_en;

  always_comb begin
    wr_en = bus.i_wen && bus.i_wdata_valid && (bus.i_waddr < DEPTH);
    pc_d  = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_WIDTH'(1);
  end

  // Writes ignore reset and stall so the program can be loaded while the core is held.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[bus.i_waddr[IDX_W-1:0]] <= bus.i_wdata;
    end
  end

  // Stage 1 samples the array on the issue edge, so a same-edge write is seen as old data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else if (!bus.i_stall) begin
      pc_q        <= pc_d;
      s1_valid_q  <= 1'b1;
      s1_addr_q   <= pc_q;
      s1_data_q   <= mem_q[pc_q[IDX_W-1:0]];
      out_valid_q <= s1_valid_q;
      out_pc_q    <= s1_addr_q;
      out_instr_q <= INSTR_WIDTH'(s1_data_q);
    end
  end

  assign bus.o_pc          = out_pc_q;
  assign bus.o_instr_valid = out_valid_q;
  assign bus.o_instr       = out_instr_q;
endmodule

// File: tb/tb_bc_fetch_unit.sv
// tb/tb_bc_fetch_unit.sv - self-checking bench for bc_fetch_unit
module tb_bc_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bc_fetch_unit_if bus ();

  bc_fetch_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    bit          rst, stall, wen, wdv;
    logic [31:0] waddr, wdata;
    bit          ev;
    logic [31:0] epc, einstr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb_q[$];
  logic [31:0] model_mem [1024];
  int          model_pc;
  bit          exp_v;
  logic [31:0] exp_pc, exp_instr;
  int          total = 0;
  int          bad = 0;

  task automatic cmp(input string name, input bit v, input logic [31:0] pc, input logic [31:0] instr,
                     input bit ev, input logic [31:0] epc, input logic [31:0] einstr);
    total++;
    if (v !== ev || pc !== epc || instr !== einstr) begin
      bad++;
      $display("FAIL %s: got valid=%0b pc=%0d instr=%h, want valid=%0b pc=%0d instr=%h",
               name, v, pc, instr, ev, epc, einstr);
    end
  endtask

  function automatic void add(input bit r, input bit s, input bit we, input bit wdv,
                              input logic [31:0] wa, input logic [31:0] wd,
                              input bit ev, input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.stall = s; v.wen = we; v.wdv = wdv; v.waddr = wa; v.wdata = wd;
    v.ev = ev; v.epc = epc; v.einstr = ei;
    vecs.push_back(v);
  endfunction

  // Scoreboard: a read issued on an edge is queued, then popped on the next advancing edge.
  task automatic model_edge();
    sb_t e;
    if (rst) begin
      sb_q.delete();
      exp_v = 1'b0; exp_pc = '0; exp_instr = '0; model_pc = 0;
    end else if (!bus.i_stall) begin
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        exp_v = 1'b1; exp_pc = e.addr; exp_instr = e.data;
      end
      e.addr = 32'(model_pc);
      e.data = model_mem[model_pc];
      sb_q.push_back(e);
      model_pc = (model_pc + 1) % 1024;
    end
    if (bus.i_wen && bus.i_wdata_valid && bus.i_waddr < 32'd1024)
      model_mem[bus.i_waddr[9:0]] = bus.i_wdata;
  endtask

  task automatic step(input bit r, input bit s, input bit we, input bit wdv,
                      input logic [31:0] wa, input logic [31:0] wd);
    rst = r;
    bus.i_stall = s;
    bus.i_wen = we;
    bus.i_wdata_valid = wdv;
    bus.i_waddr = wa;
    bus.i_wdata = wd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp("scoreboard", bus.o_instr_valid, bus.o_pc, bus.o_instr, exp_v, exp_pc, exp_instr);
  endtask

  initial begin
    logic [31:0] pre [6];
    logic [31:0] prev_pc;
    int          wraps;
    bit          s, we, wdv;
    logic [31:0] wa;

    pre[0] = 32'h0000_0114; pre[1] = 32'h0000_0214; pre[2] = 32'hAAAA_AAAA;
    pre[3] = 32'hAAAA_AAAB; pre[4] = 32'hAAAA_AAAC; pre[5] = 32'hAAAA_AAAD;
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    model_pc = 0; exp_v = 0; exp_pc = '0; exp_instr = '0;

    for (int i = 0; i < 6; i++) add(1, 0, 1, 1, 32'(i), pre[i], 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, pre[0]);
    add(0, 0, 0, 0, 0, 0, 1, 1, pre[1]);
    add(0, 0, 0, 0, 0, 0, 1, 2, pre[2]);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 1, 2, pre[2]);
    add(0, 0, 0, 0, 0, 0, 1, 3, pre[3]);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'd7, 32'h1234_5678, 1, 0, pre[0]);
    add(0, 0, 1, 1, 32'd1024, 32'h5555_5555, 1, 1, pre[1]);
    for (int i = 2; i < 6; i++) add(0, 0, 0, 0, 0, 0, 1, 32'(i), pre[i]);
    add(0, 0, 0, 0, 0, 0, 1, 6, 0);
    add(0, 0, 0, 0, 0, 0, 1, 7, 0);
    add(0, 0, 0, 0, 0, 0, 1, 8, 0);
    add(0, 0, 1, 1, 32'd10, 32'hDEAD_BEEF, 1, 9, 0);
    add(0, 0, 0, 0, 0, 0, 1, 10, 0);
    add(0, 0, 0, 0, 0, 0, 1, 11, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].wen, vecs[i].wdv, vecs[i].waddr, vecs[i].wdata);
      cmp($sformatf("vec%0d", i), bus.o_instr_valid, bus.o_pc, bus.o_instr,
          vecs[i].ev, vecs[i].epc, vecs[i].einstr);
    end

    // Long run across the wrap with random stalls and writes away from the low addresses.
    prev_pc = bus.o_pc;
    wraps = 0;
    for (int c = 0; c < 1300; c++) begin
      s   = ($urandom_range(7) == 0);
      we  = ($urandom_range(3) == 0);
      wdv = ($urandom_range(1) == 1);
      wa  = ($urandom_range(4) == 0) ? 32'(1024 + $urandom_range(50)) : 32'($urandom_range(100, 900));
      step(0, s, we, wdv, wa, $urandom);
      if (bus.o_instr_valid && bus.o_pc != prev_pc) begin
        if (prev_pc == 32'd1023) begin
          wraps++;
          cmp("wrap_to_0", bus.o_instr_valid, bus.o_pc, bus.o_instr, 1, 0, pre[0]);
        end
        if (wraps > 0 && bus.o_pc == 32'd10)
          cmp("collision_new", bus.o_instr_valid, bus.o_pc, bus.o_instr, 1, 10, 32'hDEAD_BEEF);
        if (wraps > 0 && bus.o_pc == 32'd7)
          cmp("gated_write", bus.o_instr_valid, bus.o_pc, bus.o_instr, 1, 7, 0);
      end
      prev_pc = bus.o_pc;
    end
    cmp("wrap_count", 1, 32'(wraps), 0, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
